// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

   // Bits added per cycle by the ripple slice
   localparam int unsigned SLICE = 4;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_add4_slice.sv
// 4-bit ripple-carry adder slice, also exposing the carry into its top bit.
module add4_slice
   import nibble_serial_adder_pkg::*;
(
   input  logic [SLICE-1:0] a4,
   input  logic [SLICE-1:0] b4,
   input  logic             ci,
   output logic [SLICE-1:0] s4,
   output logic             co,
   output logic             c3
);

   logic [SLICE:0] c;

   // Ripple the carry through each bit of the slice
   always_comb begin
      c    = '0;
      s4   = '0;
      c[0] = ci;
      for (int i = 0; i < int'(SLICE); i++) begin
         s4[i]   = a4[i] ^ b4[i] ^ c[i];
         c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
      end
      co = c[SLICE];
      c3 = c[SLICE-1];
   end

endmodule : add4_slice

// File: rtl/nibble_serial_adder.sv
// Serial adder: one nibble per cycle through a shared 4-bit slice, with
// valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder
   import nibble_serial_adder_pkg::state_t;
   import nibble_serial_adder_pkg::IDLE;
   import nibble_serial_adder_pkg::CALC;
   import nibble_serial_adder_pkg::DONE;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = nibble_serial_adder_pkg::SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  opa_q, opa_d;
   logic [WIDTH-1:0]  opb_q, opb_d;
   logic [WIDTH-1:0]  sum_d;
   logic              cout_d, ovf_d;
   logic              in_ready_d, out_valid_d, busy_d;

   int unsigned       base;
   logic [WIDTH-1:0]  mask;
   logic [SLICE-1:0]  sl_a, sl_b, sl_s;
   logic              sl_co, sl_c3;

   // Select the current nibble of each registered operand
   always_comb begin
      base = 32'(idx_q) * SLICE;
      sl_a = SLICE'(opa_q >> base);
      sl_b = SLICE'(opb_q >> base);
      mask = WIDTH'({SLICE{1'b1}}) << base;
   end

   add4_slice u_slice (
      .a4 (sl_a),
      .b4 (sl_b),
      .ci (carry_q),
      .s4 (sl_s),
      .co (sl_co),
      .c3 (sl_c3)
   );

   // State, datapath and registered-output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         sum       <= sum_d;
         cout      <= cout_d;
         ovf       <= ovf_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
      end
   end

   // Next-state, slice write-back and next values of the handshake outputs
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum;
      cout_d  = cout;
      ovf_d   = ovf;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               opa_d   = a;
               opb_d   = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // Carry out of the MSB slice lands only in cout, never in sum
            sum_d   = (sum & ~mask) | (WIDTH'(sl_s) << base);
            carry_d = sl_co;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = sl_co;
               ovf_d   = sl_c3 ^ sl_co;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

endmodule : nibble_serial_adder

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter WIDTH, 16, operand width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, 4, bits added per cycle; fixed at 4.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  operand request valid.
REQ-006 Port in_ready  output  1  block accepts operands; transfer when in_valid && in_ready at a rising edge.
REQ-007 Port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry into bit 0.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts result; transfer when out_valid && out_ready at a rising edge.
REQ-012 Port sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 Port cout  output  1  carry out of bit WIDTH-1.
REQ-014 Port ovf  output  1  signed overflow = carry into MSB XOR cout.
REQ-015 Port busy  output  1  high in CALC or DONE.

Function
REQ-016 FSM SHALL have states IDLE, CALC, DONE; NSLICE = WIDTH/SLICE.
REQ-017 IDLE: in_ready=1, out_valid=0; on input transfer, register a, b, cin into operand/carry registers, clear slice index, go to CALC.
REQ-018 CALC: each cycle, slice idx of registered A/B plus carry register through one 4-bit adder slice; sum bits [idx*4+3:idx*4] written, carry register <= slice carry-out, idx++.
REQ-019 CALC -> DONE after slice NSLICE-1 processed; ovf captured from last slice's carry into bit 3 XOR its carry-out.
REQ-020 Latency: out_valid SHALL rise exactly NSLICE cycles after the input-transfer edge (4 for default).
REQ-021 DONE: out_valid=1; sum, cout, ovf held stable until output transfer; then go to IDLE.
REQ-022 in_ready SHALL be 0 in CALC and DONE; in_valid there is ignored, operands not sampled.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 No same-cycle input acceptance on DONE exit; throughput one op per NSLICE+2 cycles minimum.
REQ-025 sum/cout/ovf SHALL change only on the CALC slice writes and reset; intermediate sum visible during CALC is don't-care to consumers.
REQ-026 Wrap-around: carry out of MSB goes only to cout, never re-enters sum.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-028 Reset during CALC or DONE SHALL abandon the operation with no result transfer.

Structure
REQ-029 Shared package SHALL hold state enum (IDLE, CALC, DONE) and SLICE constant.
REQ-030 One sub-module add4_slice (4-bit ripple adder: a4, b4, ci -> s4, co, c3 carry into bit 3) instantiated once, reused every CALC cycle.

Verification
REQ-031 0xFFFF + 0x0001, cin=0 -> sum 0x0000, cout=1, ovf=0, out_valid 4 cycles after accept.
REQ-032 0x7FFF + 0x0001, cin=0 -> sum 0x8000, cout=0, ovf=1.
REQ-033 0x1234 + 0x4321, cin=1 -> sum 0x5556, cout=0; out_ready held low 3 cycles -> outputs and out_valid stable throughout.
REQ-034 in_valid with 0xAAAA/0x5555 during CALC of prior op -> ignored, in_ready=0, prior result unaffected.
REQ-035 rst_n low in 2nd CALC cycle -> IDLE, all outputs 0, in_ready=1 after release; next op 0x0001+0x0001 -> 0x0002.
REQ-036 Random 1000 ops with random backpressure -> every result equals a+b+cin reference model.
